// File: rtl/minisys_pkg.sv
// Shared Minisys-1A constants: branch opcodes, REGIMM rt codes and the
// 2-bit saturating branch-history counter type.
package minisys_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_SNT = 2'b00;
  localparam bht_ctr_t CTR_WNT = 2'b01;
  localparam bht_ctr_t CTR_WT  = 2'b10;
  localparam bht_ctr_t CTR_ST  = 2'b11;
  localparam bht_ctr_t CTR_RST = CTR_WNT;

  function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
    if (taken) return (c == CTR_ST)  ? CTR_ST  : bht_ctr_t'(c + 2'd1);
    else       return (c == CTR_SNT) ? CTR_SNT : bht_ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_decode.sv
// Combinational conditional-branch detector for a 32-bit Minisys-1A word.
// Shared by the IF-side predictor and the ID-stage decoder.
module branch_decode
  import minisys_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_is_branch
);

  logic w_unused_fields;
  assign w_unused_fields = ^{i_instr[25:21], i_instr[15:0]};

  always_comb begin
    o_is_branch = 1'b0;
    case (i_instr[31:26])
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: o_is_branch = 1'b1;
      OP_REGIMM: begin
        case (i_instr[20:16])
          RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL: o_is_branch = 1'b1;
          default: o_is_branch = 1'b0;
        endcase
      end
      default: o_is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_branch_predictor.sv
// IF-stage dynamic branch predictor: 2-bit BHT lookup, IF/ID prediction slot,
// ID-stage misprediction detection, BHT training and saturating statistics.
module if_branch_predictor
  import minisys_pkg::*;
#(
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned ROM_ADR_W = 14,
  parameter int unsigned STAT_W    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ROM_ADR_W-1:0] if_pc_word,
  input  logic [31:0]          if_instr,
  input  logic                 if_id_write,
  input  logic                 flush,
  input  logic                 id_br_valid,
  input  logic                 id_br_taken,
  output logic                 IFBranch,
  output logic                 nBranch,
  output logic                 ntBranch,
  output logic [STAT_W-1:0]    stat_branches,
  output logic [STAT_W-1:0]    stat_mispred
);

  localparam int unsigned BHT_N = 2 ** BHT_IDX_W;

  bht_ctr_t               r_bht [BHT_N];
  logic                   r_pred_valid;
  logic                   r_pred_taken;
  logic [BHT_IDX_W-1:0]   r_pred_idx;
  logic [STAT_W-1:0]      r_stat_br;
  logic [STAT_W-1:0]      r_stat_mp;

  logic                   w_is_branch;
  logic [BHT_IDX_W-1:0]   w_idx;
  logic                   w_resolve;
  logic                   w_train;
  logic                   w_mispred;
  logic                   w_unused_pc;

  branch_decode u_decode (
    .i_instr     (if_instr),
    .o_is_branch (w_is_branch)
  );

  assign w_idx       = if_pc_word[BHT_IDX_W-1:0];
  assign w_unused_pc = ^if_pc_word[ROM_ADR_W-1:BHT_IDX_W];

  assign IFBranch  = w_is_branch & r_bht[w_idx][1];
  assign w_resolve = id_br_valid & r_pred_valid & ~flush;
  assign nBranch   = w_resolve & r_pred_taken & ~id_br_taken;
  assign ntBranch  = w_resolve & ~r_pred_taken & id_br_taken;
  assign w_mispred = nBranch | ntBranch;
  assign w_train   = w_resolve & if_id_write;

  assign stat_branches = r_stat_br;
  assign stat_mispred  = r_stat_mp;

  always_ff @(negedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_N; i++) r_bht[i] <= CTR_RST;
    end else if (w_train) begin
      r_bht[r_pred_idx] <= ctr_next(r_bht[r_pred_idx], id_br_taken);
    end
  end

  // A stalled mispredict keeps its slot so it resolves (and trains) once on
  // release; it only kills the IF word when the pipeline actually advances.
  always_ff @(negedge clock) begin
    if (reset) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= '0;
    end else if (flush) begin
      r_pred_valid <= 1'b0;
    end else if (!if_id_write) begin
      r_pred_valid <= r_pred_valid;
    end else if (w_mispred) begin
      r_pred_valid <= 1'b0;
    end else begin
      r_pred_valid <= w_is_branch;
      r_pred_taken <= IFBranch;
      r_pred_idx   <= w_idx;
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (w_train) begin
      if (r_stat_br != '1) r_stat_br <= r_stat_br + 1'b1;
      if (w_mispred && (r_stat_mp != '1)) r_stat_mp <= r_stat_mp + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_branch_predictor.sv
// Self-checking bench for if_branch_predictor: directed scenarios plus random
// traffic compared every cycle against an array-based behavioural model.
module tb_if_branch_predictor;

  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  localparam logic [31:0] I_BEQ  = 32'h1085_0003;
  localparam logic [31:0] I_BNE  = 32'h1485_0003;
  localparam logic [31:0] I_J    = 32'h0800_0004;
  localparam logic [31:0] I_ADDI = 32'h2001_0005;
  localparam logic [31:0] I_RI2  = 32'h0402_0004;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [13:0]   if_pc_word = '0;
  logic [31:0]   if_instr = '0;
  logic          if_id_write = 1'b1;
  logic          flush = 1'b0;
  logic          id_br_valid = 1'b0;
  logic          id_br_taken = 1'b0;
  logic          IFBranch, nBranch, ntBranch;
  logic [SW-1:0] stat_branches, stat_mispred;

  if_branch_predictor #(.BHT_IDX_W(6), .ROM_ADR_W(14), .STAT_W(SW)) dut (
    .clock         (clock),
    .reset         (reset),
    .if_pc_word    (if_pc_word),
    .if_instr      (if_instr),
    .if_id_write   (if_id_write),
    .flush         (flush),
    .id_br_valid   (id_br_valid),
    .id_br_taken   (id_br_taken),
    .IFBranch      (IFBranch),
    .nBranch       (nBranch),
    .ntBranch      (ntBranch),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: counters as plain integers 0..3.
  int m_bht [64];
  bit m_pv, m_pt;
  int m_pidx;
  int m_sb, m_sm;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_br(input logic [31:0] w);
    int op, rt;
    op = int'(w[31:26]);
    rt = int'(w[20:16]);
    if (op >= 4 && op <= 7) return 1'b1;
    if (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) return 1'b1;
    return 1'b0;
  endfunction

  // Outputs are combinational on inputs driven after the falling edge, so
  // the rising edge is a stable mid-cycle sample point.
  always @(posedge clock) begin
    int  idx;
    bit  e_ifb, act, e_nb, e_ntb;
    idx   = int'(if_pc_word) % 64;
    e_ifb = is_br(if_instr) && (m_bht[idx] >= 2);
    act   = id_br_valid && m_pv && !flush;
    e_nb  = act && m_pt && !id_br_taken;
    e_ntb = act && !m_pt && id_br_taken;
    if (chk_en) begin
      chk("IFBranch", int'(IFBranch), int'(e_ifb));
      chk("nBranch", int'(nBranch), int'(e_nb));
      chk("ntBranch", int'(ntBranch), int'(e_ntb));
      chk("stat_branches", int'(stat_branches), m_sb);
      chk("stat_mispred", int'(stat_mispred), m_sm);
    end
    if (reset) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_pv = 0; m_pt = 0; m_pidx = 0; m_sb = 0; m_sm = 0;
    end else begin
      if (act && if_id_write) begin
        m_bht[m_pidx] = id_br_taken ? ((m_bht[m_pidx] == 3) ? 3 : m_bht[m_pidx] + 1)
                                    : ((m_bht[m_pidx] == 0) ? 0 : m_bht[m_pidx] - 1);
        if (m_sb < SMAX) m_sb++;
        if ((e_nb || e_ntb) && m_sm < SMAX) m_sm++;
      end
      if (flush) m_pv = 0;
      else if (!if_id_write) ;
      else if (e_nb || e_ntb) m_pv = 0;
      else begin
        m_pv = is_br(if_instr); m_pt = e_ifb; m_pidx = idx;
      end
    end
  end

  task automatic apply(input logic rst, input logic [13:0] pc, input logic [31:0] ins,
                       input logic wr, input logic fl, input logic bv, input logic bt);
    @(negedge clock);
    #1;
    reset = rst; if_pc_word = pc; if_instr = ins;
    if_id_write = wr; flush = fl; id_br_valid = bv; id_br_taken = bt;
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [13:0] pc, input logic [31:0] ins);
    apply(1'b0, pc, ins, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic bt);
    apply(1'b0, 14'h0020, 32'h0, 1'b1, 1'b0, 1'b1, bt);
  endtask

  initial begin
    int exp_seq [4];
    logic [31:0] r, r2, ins;
    logic [4:0]  rt;
    exp_seq = '{2, 3, 3, 3};

    // Reset state
    apply(1'b1, 14'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    apply(1'b1, 14'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_stat_br", int'(stat_branches), 0);
    chk("rst_ntBranch", int'(ntBranch), 0);
    chk("rst_IFBranch", int'(IFBranch), 0);

    // Cold beq at 0x10 trains on a taken resolution
    fetch(14'h0010, I_BEQ);
    chk("t1_ifb_cold", int'(IFBranch), 0);
    resolve(1'b1);
    chk("t1_ntBranch", int'(ntBranch), 1);
    chk("t1_model_ctr", m_bht[16], 2);
    fetch(14'h0010, I_BEQ);
    chk("t1_ifb_warm", int'(IFBranch), 1);
    resolve(1'b1);

    // Saturation up at idx 5, then one not-taken
    for (int k = 0; k < 4; k++) begin
      fetch(14'h0005, I_BEQ);
      resolve(1'b1);
      chk("t2_model_ctr", m_bht[5], exp_seq[k]);
    end
    fetch(14'h0005, I_BEQ);
    resolve(1'b0);
    chk("t2_nBranch", int'(nBranch), 1);
    chk("t2_model_dec", m_bht[5], 2);
    fetch(14'h0005, I_BEQ);
    chk("t2_ifb_still", int'(IFBranch), 1);
    resolve(1'b1);

    // Stalled mispredict trains exactly once on release
    fetch(14'h0009, I_BNE);
    resolve(1'b1);
    fetch(14'h0009, I_BNE);
    chk("t3_ifb", int'(IFBranch), 1);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 14'h0020, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t3_stall_nb", int'(nBranch), 1);
      chk("t3_stall_sb", int'(stat_branches), 9);
    end
    apply(1'b0, 14'h0020, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3_release_nb", int'(nBranch), 1);
    fetch(14'h0020, 32'h0);
    chk("t3_sb_after", int'(stat_branches), 10);
    chk("t3_model_ctr", m_bht[9], 1);

    // Flush kills a resolving branch
    fetch(14'h0005, I_BEQ);
    apply(1'b0, 14'h0020, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_flush_nb", int'(nBranch), 0);
    apply(1'b0, 14'h0020, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_after_nb", int'(nBranch), 0);
    chk("t4_sb", int'(stat_branches), 10);

    // Same-index hazard at idx 7: lookup sees the pre-update value
    fetch(14'h0007, I_BEQ);
    resolve(1'b0);
    fetch(14'h0007, I_BEQ);
    apply(1'b0, 14'h0007, I_BEQ, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5_ntBranch", int'(ntBranch), 1);
    chk("t5_ifb_same", int'(IFBranch), 0);
    chk("t5_model_ctr", m_bht[7], 1);
    fetch(14'h0007, I_BEQ);
    chk("t5_ifb_next", int'(IFBranch), 0);
    fetch(14'h0020, 32'h0);

    // Non-branch words on a strongly-taken entry
    for (int k = 0; k < 2; k++) begin
      fetch(14'h000C, I_BEQ);
      resolve(1'b1);
    end
    chk("t6_model_ctr", m_bht[12], 3);
    fetch(14'h000C, I_J);
    chk("t6_ifb_j", int'(IFBranch), 0);
    resolve(1'b1);
    chk("t6_nt_j", int'(ntBranch), 0);
    fetch(14'h000C, I_ADDI);
    chk("t6_ifb_addi", int'(IFBranch), 0);
    resolve(1'b1);
    fetch(14'h000C, I_RI2);
    chk("t6_ifb_ri2", int'(IFBranch), 0);
    resolve(1'b1);
    chk("t6_nt_ri2", int'(ntBranch), 0);

    // Drive the mispredict counter into saturation
    for (int k = 0; k < 20; k++) begin
      fetch(14'h001E, I_BEQ);
      resolve(m_bht[30] < 2);
    end
    fetch(14'h0020, 32'h0);
    chk("sat_mispred", int'(stat_mispred), SMAX);
    chk("sat_branches", int'(stat_branches), SMAX);

    // Random traffic against the model
    apply(1'b1, 14'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      r  = $urandom;
      r2 = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2: ins = {3'b000, 1'b1, r2[1:0], r[25:0]};
        3: begin
          case ($urandom_range(0, 5))
            0: rt = 5'd0;  1: rt = 5'd1;  2: rt = 5'd16;  3: rt = 5'd17;
            default: rt = r2[4:0];
          endcase
          ins = {6'b000001, r[25:21], rt, r[15:0]};
        end
        4: ins = I_J;
        default: ins = r;
      endcase
      apply(($urandom_range(0, 99) == 0), {r2[13:4], r2[23:20]}, ins,
            ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 5),
            r2[30], r2[31]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
